// File: rtl/ascon_hash256_ctrl.sv
// Ascon-Hash256 sequencer driving a word-addressed Ascon permutation core.
// Optional macro ASCON_XOF_EN adds Ascon-XOF128 IV selection and a programmable output length.
module ascon_hash256_ctrl #(
    parameter logic [63:0] IV_HASH      = 64'h0000080100CC0002,
    parameter int unsigned DIGEST_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
`ifdef ASCON_XOF_EN
    input  logic        xof_i,
    input  logic [15:0] out_words_i,
`endif
    output logic        busy_o,
    input  logic        msg_valid_i,
    output logic        msg_ready_o,
    input  logic [63:0] msg_data_i,
    input  logic        msg_last_i,
    input  logic [3:0]  msg_bytes_i,
    output logic        dig_valid_o,
    output logic [63:0] dig_data_o,
    input  logic        dig_ready_i,
    output logic        core_start_perm_o,
    output logic        core_mode_o,
    output logic [2:0]  core_word_sel_o,
    output logic [63:0] core_data_o,
    output logic        core_write_en_o,
    output logic        core_xor_en_o,
    input  logic [63:0] core_data_i,
    input  logic        core_perm_done_i
);

`ifdef ASCON_XOF_EN
    localparam int unsigned CNT_W  = 16;
    localparam logic [63:0] IV_XOF = 64'h0000080000CC0003;
`else
    localparam int unsigned CNT_W  = 3;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_WR,
        S_PERM,
        S_WAIT,
        S_ABSORB,
        S_PAD,
        S_SQUEEZE
    } state_t;

    state_t             state;
    state_t             ret_state;
    logic [2:0]         sel_q;
    logic [63:0]        data_q;
    logic               wr_q;
    logic               xor_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   limit;
    logic [63:0]        init_iv;
    logic               msg_hs;
    logic [3:0]         last_n;
    logic [5:0]         last_shift;
    logic [63:0]        absorb_data;

`ifdef ASCON_XOF_EN
    assign init_iv = xof_i ? IV_XOF : IV_HASH;
`else
    assign init_iv = IV_HASH;
    assign limit   = CNT_W'(DIGEST_WORDS);
`endif

    assign cnt_inc    = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign msg_hs     = (state == S_ABSORB) && msg_ready_o && msg_valid_i;
    assign last_n     = (msg_bytes_i > 4'd8) ? 4'd8 : msg_bytes_i;
    assign last_shift = {last_n[2:0], 3'b000};

    // Short final word: keep the valid bytes and place the 0x01 pad byte right after them.
    always_comb begin
        absorb_data = msg_data_i;
        if (msg_last_i && (last_n < 4'd8)) begin
            absorb_data = (msg_data_i & ~(64'hFFFF_FFFF_FFFF_FFFF << last_shift))
                        | (64'h1 << last_shift);
        end
    end

    // Message words are XORed into the core in the handshake cycle itself.
    assign core_xor_en_o   = xor_q | msg_hs;
    assign core_data_o     = msg_hs ? absorb_data : data_q;
    assign core_write_en_o = wr_q;
    assign core_word_sel_o = sel_q;
    assign core_mode_o     = 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            ret_state         <= S_IDLE;
            busy_o            <= 1'b0;
            msg_ready_o       <= 1'b0;
            dig_valid_o       <= 1'b0;
            dig_data_o        <= '0;
            core_start_perm_o <= 1'b0;
            wr_q              <= 1'b0;
            xor_q             <= 1'b0;
            sel_q             <= '0;
            data_q            <= '0;
            cnt               <= '0;
`ifdef ASCON_XOF_EN
            limit             <= CNT_W'(DIGEST_WORDS);
`endif
        end else begin
            core_start_perm_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        busy_o <= 1'b1;
                        cnt    <= '0;
                        wr_q   <= 1'b1;
                        sel_q  <= '0;
                        data_q <= init_iv;
                        state  <= S_INIT_WR;
`ifdef ASCON_XOF_EN
                        limit  <= (out_words_i == 16'd0) ? 16'd1 : out_words_i;
`endif
                    end
                end
                S_INIT_WR: begin
                    if (sel_q == 3'd4) begin
                        wr_q              <= 1'b0;
                        sel_q             <= '0;
                        data_q            <= '0;
                        core_start_perm_o <= 1'b1;
                        ret_state         <= S_ABSORB;
                        state             <= S_PERM;
                    end else begin
                        sel_q  <= sel_q + 3'd1;
                        data_q <= '0;
                    end
                end
                // Pulse cycle: a done seen here belongs to nothing we asked for.
                S_PERM: state <= S_WAIT;
                S_WAIT: begin
                    if (core_perm_done_i) begin
                        state <= ret_state;
                        if (ret_state == S_ABSORB) begin
                            msg_ready_o <= 1'b1;
                        end else if (ret_state == S_PAD) begin
                            xor_q  <= 1'b1;
                            data_q <= 64'h1;
                        end
                    end
                end
                S_ABSORB: begin
                    if (msg_hs) begin
                        msg_ready_o       <= 1'b0;
                        core_start_perm_o <= 1'b1;
                        state             <= S_PERM;
                        if (!msg_last_i) begin
                            ret_state <= S_ABSORB;
                        end else if (last_n == 4'd8) begin
                            ret_state <= S_PAD;
                        end else begin
                            ret_state <= S_SQUEEZE;
                        end
                    end
                end
                S_PAD: begin
                    xor_q             <= 1'b0;
                    data_q            <= '0;
                    core_start_perm_o <= 1'b1;
                    ret_state         <= S_SQUEEZE;
                    state             <= S_PERM;
                end
                S_SQUEEZE: begin
                    if (!dig_valid_o) begin
                        dig_valid_o <= 1'b1;
                        dig_data_o  <= core_data_i;
                    end else if (dig_ready_i) begin
                        dig_valid_o <= 1'b0;
                        cnt         <= cnt_inc;
                        if (cnt_inc < limit) begin
                            core_start_perm_o <= 1'b1;
                            ret_state         <= S_SQUEEZE;
                            state             <= S_PERM;
                        end else begin
                            busy_o <= 1'b0;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
